uart_pipe_fifo: RTL and testbench
=================================

UART_PIPE_FIFO -- requirements
Module: uart_pipe_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4; log2 of storage depth, so the default gives 16 bytes; legal range 1..8.
REQ-002 Port: clk_48mhz  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: flush  input  1  synchronous discard of all stored bytes.
REQ-005 Port: in_data  input  8  byte from the usb_uart out pipeline (host -> device).
REQ-006 Port: in_valid  input  1  in_data is valid.
REQ-007 Port: in_ready  output  1  FIFO accepts in_data this cycle.
REQ-008 Port: out_data  output  8  oldest stored byte, to the consumer (j1eforth core).
REQ-009 Port: out_valid  output  1  out_data is valid.
REQ-010 Port: out_ready  input  1  consumer takes out_data this cycle.
REQ-011 Port: level  output  DEPTH_LOG2+1  number of bytes stored.

Function
REQ-012 SHALL implement a first-in first-out byte queue with DEPTH = 2**DEPTH_LOG2 entries, indexed by DEPTH_LOG2-bit read and write pointers that wrap modulo DEPTH.
REQ-013 Push SHALL occur iff in_valid && in_ready; pop SHALL occur iff out_valid && out_ready.
REQ-014 in_ready SHALL equal (level != DEPTH) and SHALL NOT depend on out_ready; a full FIFO never accepts, even if a pop occurs in the same cycle.
REQ-015 out_valid SHALL equal (level != 0); out_data SHALL equal the entry at the read pointer (combinational read of the storage array).
REQ-016 Minimum latency SHALL be one cycle: a byte pushed at edge N is presented on out_valid/out_data after edge N, not before.
REQ-017 Simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and advance both pointers.
REQ-018 out_data and out_valid SHALL stay stable while out_valid && !out_ready; byte order SHALL be preserved across pointer wrap-around.
REQ-019 flush SHALL take priority over push and pop in the same cycle: pointers and level become 0 after the edge, and the in_data byte presented in that cycle is dropped.
REQ-020 level SHALL count exactly: +1 on push only, -1 on pop only; it SHALL never exceed DEPTH or underflow.

Reset
REQ-021 On reset, the pointers SHALL be cleared and level = 0, out_valid = 0 and in_ready = 1 after the edge; reset overrides flush, push and pop.
REQ-022 Storage array contents SHALL NOT be reset; out_data is don't-care while out_valid = 0.
REQ-023 Reset asserted mid-transfer SHALL discard all stored bytes; no stale byte SHALL appear on out_valid afterwards.

Configuration
REQ-024 Macro UART_PIPE_FIFO_BYPASS_EN.
REQ-025 Defined: when level = 0, flush = 0, in_valid = 1 and out_ready = 1, the FIFO SHALL drive out_valid = 1 and out_data = in_data combinationally, and complete the transfer without storing the byte (level stays 0). out_valid SHALL still be 1 whenever level != 0.
REQ-026 Not defined: no combinational path SHALL exist from in_* to out_*; REQ-016 latency applies unconditionally.

Structure
REQ-027 DEPTH derivation and the byte width constant (8) SHALL live in the shared pipe defines include, alongside the existing pipeline definitions.
REQ-028 Sub-module: uart_pipe_fifo_mem, a simple dual-port array with one synchronous write port and one asynchronous read port; pointer, level and handshake logic stay in the top module.

Verification
REQ-029 Push 0x41, 0x42, 0x43 with out_ready = 0 -> level = 3 and out_data = 0x41; then raise out_ready -> 0x41, 0x42, 0x43 are popped on consecutive cycles and level returns to 0.
REQ-030 DEPTH = 16: push 16 bytes -> in_ready = 0 and level = 16; a 17th in_valid is not accepted; one pop -> in_ready = 1 on the next cycle.
REQ-031 Continuous push and pop for 40 bytes (0x00..0x27) -> in-order output across pointer wrap; level stays constant while push and pop are simultaneous.
REQ-032 With 5 bytes stored, assert flush together with in_valid (0x55) -> level = 0 and out_valid = 0 next cycle; 0x55 never appears on the output.
REQ-033 Assert reset with 7 bytes stored and out_ready = 1 -> level = 0, out_valid = 0, in_ready = 1 next cycle; no further output until a new push.
REQ-034 Empty FIFO, in_valid = 1 with 0x7E, out_ready = 1 -> with UART_PIPE_FIFO_BYPASS_EN: out_valid = 1 with 0x7E in the same cycle and level stays 0; without it: out_valid = 0 in that cycle, then 0x7E appears in the next cycle.

Source files
------------

// File: rtl/uart_pipe_fifo_pkg.sv
// Shared pipe definitions: byte width and FIFO depth derivation.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package uart_pipe_fifo_pkg;

    // Width of every byte moving through the usb_uart pipeline.
    localparam int BYTE_W = 8;

    // Number of storage entries for a given log2 depth.
    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/uart_pipe_fifo_mem.sv
// Simple dual-port byte array: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port after the writing edge; read is combinational.
// Backpressure: none; the caller only writes when there is room.
module uart_pipe_fifo_mem
    import uart_pipe_fifo_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk_48mhz,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [BYTE_W-1:0] rd_data
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    // Contents are deliberately not reset; readers gate on the FIFO level.
    logic [BYTE_W-1:0] mem [DEPTH];

    // Write port: store the byte on the rising edge when enabled.
    always_ff @(posedge clk_48mhz) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_pipe_fifo.sv
// Byte FIFO between the usb_uart out pipe and the j1eforth core; optional bypass via UART_PIPE_FIFO_BYPASS_EN.
// Latency: one cycle push-to-output by default; zero cycles on an empty FIFO when bypass is compiled in.
// Backpressure: in_ready drops only when full (independent of out_ready); out_data holds while out_ready is low.
module uart_pipe_fifo
    import uart_pipe_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_48mhz,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [BYTE_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BYTE_W-1:0]     out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   level
);

    // Level value meaning "every entry occupied" (exactly DEPTH).
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [BYTE_W-1:0]     rd_data;
    logic                  stored_vld;
    logic                  push;
    logic                  pop;

    assign stored_vld = (level != '0);
    // A full FIFO refuses input even if the consumer pops in the same cycle.
    assign in_ready   = (level != FULL_LEVEL);
    assign pop        = stored_vld && out_ready;

`ifdef UART_PIPE_FIFO_BYPASS_EN
    // Empty FIFO with a willing consumer: hand the byte straight through, never stored.
    logic bypass;
    assign bypass    = (level == '0) && !flush && in_valid && out_ready;
    assign out_valid = stored_vld || bypass;
    assign out_data  = bypass ? in_data : rd_data;
    assign push      = in_valid && in_ready && !bypass;
`else
    assign out_valid = stored_vld;
    assign out_data  = rd_data;
    assign push      = in_valid && in_ready;
`endif

    uart_pipe_fifo_mem #(
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk_48mhz (clk_48mhz),
        .wr_en     (push),
        .wr_addr   (wr_ptr),
        .wr_data   (in_data),
        .rd_addr   (rd_ptr),
        .rd_data   (rd_data)
    );

    // Pointer and level bookkeeping; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk_48mhz) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (DEPTH_LOG2+1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pipe_fifo.sv
module tb_uart_pipe_fifo;

    logic       clk_48mhz = 1'b0;
    logic       reset     = 1'b1;
    logic       flush     = 1'b0;
    logic [7:0] in_data   = 8'h00;
    logic       in_valid  = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] level;

    int errors = 0;
    int checks = 0;

    always #5 clk_48mhz = ~clk_48mhz;

    uart_pipe_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level)
    );

    // One cycle of stimulus plus the outputs expected mid-cycle (before the edge).
    typedef struct {
        logic       rst;
        logic       fl;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       chk;
        logic       e_ir;
        logic       e_ov;
        logic       chk_od;
        logic [7:0] e_od;
        logic [4:0] e_lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic fl, logic iv, logic [7:0] id, logic ordy,
                                logic chk, logic e_ir, logic e_ov, logic chk_od,
                                logic [7:0] e_od, logic [4:0] e_lvl);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
        v.chk = chk; v.e_ir = e_ir; v.e_ov = e_ov; v.chk_od = chk_od;
        v.e_od = e_od; v.e_lvl = e_lvl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [7:0] id, input logic ordy);
        reset = rst; flush = fl; in_valid = iv; in_data = id; out_ready = ordy;
    endtask

    // Move to the middle of the cycle where outputs are sampled.
    task automatic mid();
        @(negedge clk_48mhz);
    endtask

    // Finish the cycle: pass the active edge and settle.
    task automatic edge_step();
        @(posedge clk_48mhz);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic e_ir, input logic e_ov,
                                input logic [4:0] e_lvl);
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, e_ir});
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e_ov});
        check({tag, ".level"},     {27'd0, level},     {27'd0, e_lvl});
    endtask

    initial begin
        // Basic ordering with held output, then flush with a simultaneous push.
        vecs.push_back(mk(1,0,0,8'h00,0, 0,1,0,0,8'h00,5'd0));
        vecs.push_back(mk(0,0,0,8'h00,0, 1,1,0,0,8'h00,5'd0));
        vecs.push_back(mk(0,0,1,8'h41,0, 1,1,0,0,8'h00,5'd0));
        vecs.push_back(mk(0,0,1,8'h42,0, 1,1,1,1,8'h41,5'd1));
        vecs.push_back(mk(0,0,1,8'h43,0, 1,1,1,1,8'h41,5'd2));
        vecs.push_back(mk(0,0,0,8'h00,0, 1,1,1,1,8'h41,5'd3));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,1,1,8'h41,5'd3));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,1,1,8'h42,5'd2));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,1,1,8'h43,5'd1));
        vecs.push_back(mk(0,0,0,8'h00,0, 1,1,0,0,8'h00,5'd0));
        vecs.push_back(mk(0,0,1,8'h01,0, 1,1,0,0,8'h00,5'd0));
        vecs.push_back(mk(0,0,1,8'h02,0, 1,1,1,1,8'h01,5'd1));
        vecs.push_back(mk(0,0,1,8'h03,0, 1,1,1,1,8'h01,5'd2));
        vecs.push_back(mk(0,0,1,8'h04,0, 1,1,1,1,8'h01,5'd3));
        vecs.push_back(mk(0,0,1,8'h05,0, 1,1,1,1,8'h01,5'd4));
        vecs.push_back(mk(0,1,1,8'h55,0, 1,1,1,1,8'h01,5'd5));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,0,0,8'h00,5'd0));
        vecs.push_back(mk(0,0,0,8'h00,1, 1,1,0,0,8'h00,5'd0));

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            mid();
            if (vecs[i].chk) begin
                expect_state($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov, vecs[i].e_lvl);
                if (vecs[i].chk_od)
                    check($sformatf("vec%0d.out_data", i), {24'd0, out_data}, {24'd0, vecs[i].e_od});
            end
            edge_step();
        end

        // Fill to 16; a 17th byte is refused, even while a pop happens.
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 8'h80 + 8'(i), 0);
            edge_step();
        end
        drive(0, 0, 1, 8'hEE, 0);
        mid();
        expect_state("full", 0, 1, 5'd16);
        edge_step();
        drive(0, 0, 1, 8'hEE, 1);
        mid();
        expect_state("full_hold", 0, 1, 5'd16);
        check("full_head", {24'd0, out_data}, 32'h80);
        edge_step();
        drive(0, 0, 0, 8'h00, 0);
        mid();
        expect_state("after_pop", 1, 1, 5'd15);
        edge_step();
        for (int i = 1; i < 16; i++) begin
            drive(0, 0, 0, 8'h00, 1);
            mid();
            check($sformatf("drain%0d", i), {24'd0, out_data}, {24'd0, 8'h80 + 8'(i)});
            edge_step();
        end
        drive(0, 0, 0, 8'h00, 0);
        mid();
        expect_state("drained", 1, 0, 5'd0);
        edge_step();

        // Streaming 0x00..0x27 with one byte in flight, across pointer wrap.
        drive(0, 0, 1, 8'h00, 0);
        edge_step();
        for (int i = 1; i < 40; i++) begin
            drive(0, 0, 1, 8'(i), 1);
            mid();
            check($sformatf("stream%0d.data", i), {24'd0, out_data}, {24'd0, 8'(i - 1)});
            check($sformatf("stream%0d.level", i), {27'd0, level}, 32'd1);
            edge_step();
        end
        drive(0, 0, 0, 8'h00, 1);
        mid();
        check("stream_last", {24'd0, out_data}, 32'h27);
        edge_step();
        drive(0, 0, 0, 8'h00, 0);
        mid();
        expect_state("stream_end", 1, 0, 5'd0);
        edge_step();

        // Reset with 7 bytes stored and the consumer ready.
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 8'hA0 + 8'(i), 0);
            edge_step();
        end
        drive(1, 0, 0, 8'h00, 1);
        mid();
        check("pre_reset_level", {27'd0, level}, 32'd7);
        edge_step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 8'h00, 1);
            mid();
            expect_state($sformatf("post_reset%0d", i), 1, 0, 5'd0);
            edge_step();
        end
        drive(0, 0, 1, 8'h99, 0);
        edge_step();
        drive(0, 0, 0, 8'h00, 1);
        mid();
        expect_state("new_push", 1, 1, 5'd1);
        check("new_push.data", {24'd0, out_data}, 32'h99);
        edge_step();

        // Empty FIFO with producer and consumer both ready.
        drive(0, 0, 1, 8'h7E, 1);
        mid();
`ifdef UART_PIPE_FIFO_BYPASS_EN
        expect_state("bypass", 1, 1, 5'd0);
        check("bypass.data", {24'd0, out_data}, 32'h7E);
`else
        expect_state("no_bypass", 1, 0, 5'd0);
`endif
        edge_step();
        drive(0, 0, 0, 8'h00, 1);
        mid();
`ifdef UART_PIPE_FIFO_BYPASS_EN
        expect_state("bypass_after", 1, 0, 5'd0);
`else
        expect_state("no_bypass_after", 1, 1, 5'd1);
        check("no_bypass_after.data", {24'd0, out_data}, 32'h7E);
`endif
        edge_step();
        drive(0, 0, 0, 8'h00, 0);
        mid();
        expect_state("final", 1, 0, 5'd0);
        edge_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
